// File: rtl/insn_fetch_if.sv
// insn_fetch_if: signals shared by the fetch engine, retire, instruction memory and instruction buffer
// Ports (master = fetch engine side):
//   squash_in/squash_pc        redirect request and target from retire
//   ib_full                    instruction buffer back-pressure
//   imem_req_valid/addr/ready  request channel to instruction memory
//   imem_rsp_valid/data        in-order response channel from instruction memory
//   if_ib_packet               {valid, inst, pc, npc} = {[96], [95:64], [63:32], [31:0]}
interface insn_fetch_if;
    logic        squash_in;
    logic [31:0] squash_pc;
    logic        ib_full;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [96:0] if_ib_packet;
    modport master (
        input  squash_in, squash_pc, ib_full, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_req_addr, if_ib_packet
    );
    modport slave (
        output squash_in, squash_pc, ib_full, imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_req_addr, if_ib_packet
    );
endinterface

// File: rtl/insn_fetch.sv
// insn_fetch: sequential-PC fetch engine feeding the instruction buffer through a response queue
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      insn_fetch_if.master: squash, memory request/response, ib_full, if_ib_packet
module insn_fetch #(
    parameter int unsigned RQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic          clock,
    input logic          reset_n,
    insn_fetch_if.master bus
);
    localparam int unsigned PW = $clog2(RQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, sq_pc, head_pc;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rq_count;
    logic [CW:0]   credit_used;
    logic [31:0]   inst_mem [RQ_DEPTH];
    logic [31:0]   pc_mem [RQ_DEPTH];
    logic          req_fire, drop_rsp, push, pop, empty, full, pkt_valid;

    assign sq_pc       = bus.squash_pc & ~32'h3;
    assign rq_count    = wr_ptr_q - rd_ptr_q;
    assign empty       = wr_ptr_q == rd_ptr_q;
    assign full        = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    // Credits cover every request in flight (stale ones included) plus queued words,
    // so a push can never find the queue full.
    assign credit_used = {1'b0, outst_q} + {1'b0, rq_count};
    assign bus.imem_req_valid = reset_n && !bus.squash_in && (credit_used < (CW+1)'(RQ_DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire    = bus.imem_req_valid && bus.imem_req_ready;
    assign drop_rsp    = bus.imem_rsp_valid && (drop_q != '0);
    assign push        = bus.imem_rsp_valid && !drop_rsp && !bus.squash_in;
    assign pkt_valid   = !empty && !bus.squash_in;
    assign pop         = pkt_valid && !bus.ib_full;
    assign head_pc     = pc_mem[rd_ptr_q[PW-1:0]];
    assign bus.if_ib_packet = pkt_valid ? {1'b1, inst_mem[rd_ptr_q[PW-1:0]], head_pc, head_pc + 32'd4} : '0;

    always_comb begin
        fetch_pc_d = bus.squash_in ? sq_pc : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
        rsp_pc_d   = bus.squash_in ? sq_pc : rsp_pc_q + (push ? 32'd4 : 32'd0);
        outst_d    = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        // On squash every request still in flight becomes stale; a response arriving
        // in the squash cycle is itself discarded, hence the minus one.
        drop_d     = bus.squash_in ? outst_q - CW'(bus.imem_rsp_valid) : drop_q - CW'(drop_rsp);
        wr_ptr_d   = bus.squash_in ? '0 : wr_ptr_q + CW'(push);
        rd_ptr_d   = bus.squash_in ? '0 : rd_ptr_q + CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[wr_ptr_q[PW-1:0]] <= bus.imem_rsp_data;
            pc_mem[wr_ptr_q[PW-1:0]]   <= rsp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && full))
        else $fatal(1, "insn_fetch: response queue overflow");
endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: randomized scoreboard bench for insn_fetch with an epoch-based fetch model
module tb_insn_fetch;
    logic clock = 0;
    logic reset_n = 0;
    insn_fetch_if bus();
    insn_fetch #(.RQ_DEPTH(4), .RESET_PC(32'h0)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    req_t mem_q[$];
    exp_t sb[$];
    int total = 0, bad = 0, cyc = 0, epoch = 0, pkt_cnt = 0;
    int lat_min = 1, lat_max = 1, ready_pct = 100, full_pct = 0;
    logic [31:0] exp_pc = 0, first_pc;
    bit rsp_taken = 0, pushed_now = 0, want_first = 0, found;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE0000 ^ (a << 9);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus; the memory returns the oldest request once its latency elapses.
    // A returned word is expected in the instruction buffer only if it belongs to the current epoch.
    task automatic step(input bit sq = 0, input logic [31:0] spc = 0);
        @(posedge clock);
        #1;
        cyc++;
        rsp_taken = 0;
        pushed_now = 0;
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.ib_full = ($urandom_range(99) < full_pct);
        bus.squash_in = sq;
        bus.squash_pc = spc;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            req_t r;
            r = mem_q.pop_front();
            rsp_taken = 1;
            bus.imem_rsp_valid = 1;
            bus.imem_rsp_data = word_of(r.addr);
            if (!sq && r.epoch == epoch) begin
                sb.push_back('{r.addr, word_of(r.addr)});
                pushed_now = 1;
            end
        end
        if (sq) begin
            sb.delete();
            epoch++;
            exp_pc = {spc[31:2], 2'b00};
            want_first = 1;
            first_pc = 'x;
        end
    endtask

    task automatic release_reset();
        @(posedge clock);
        #2;
        bus.imem_req_ready = 1;
        bus.ib_full = 0;
        bus.squash_in = 0;
        bus.squash_pc = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        rsp_taken = 0;
        pushed_now = 0;
        reset_n = 1;
        cyc++;
    endtask

    always @(negedge clock) begin
        int inflight, queued;
        if (reset_n) begin
            inflight = mem_q.size() + int'(rsp_taken);
            queued = sb.size() - int'(pushed_now);
            check("req_valid", bus.imem_req_valid, !bus.squash_in && (inflight + queued < 4));
            if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_pc);
            check("pkt_valid", bus.if_ib_packet[96], queued > 0 && !bus.squash_in);
            if (bus.if_ib_packet[96] && queued > 0) begin
                check("pkt_pc", bus.if_ib_packet[63:32], sb[0].pc);
                check("pkt_inst", bus.if_ib_packet[95:64], sb[0].inst);
                check("pkt_npc", bus.if_ib_packet[31:0], sb[0].pc + 32'd4);
                if (want_first) begin
                    first_pc = bus.if_ib_packet[63:32];
                    want_first = 0;
                end
                if (!bus.ib_full) begin
                    void'(sb.pop_front());
                    pkt_cnt++;
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_q.push_back('{bus.imem_req_addr, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                exp_pc += 32'd4;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.squash_in = 0;
        bus.squash_pc = 0;
        bus.ib_full = 0;
        bus.imem_req_ready = 1;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_packet", bus.if_ib_packet, 0);
        // Streaming with a 1-cycle memory: two fill cycles, then one packet per cycle.
        want_first = 1;
        first_pc = 'x;
        pkt_cnt = 0;
        release_reset();
        repeat (39) step();
        @(negedge clock);
        #1;
        check("stream_pkt_count", pkt_cnt, 38);
        check("stream_first_pc", first_pc, 32'h0);
        // Back-pressure: credits run out and requests stop.
        full_pct = 100;
        repeat (10) step();
        @(negedge clock);
        #1;
        check("full_req_valid", bus.imem_req_valid, 0);
        full_pct = 0;
        repeat (10) step();
        // Memory not ready: address must stay put.
        ready_pct = 0;
        repeat (5) step();
        ready_pct = 100;
        repeat (5) step();
        // Squash with three requests in flight.
        lat_min = 4;
        lat_max = 4;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            @(negedge clock);
            #1;
            found = mem_q.size() == 3;
        end
        check("three_inflight_reached", found, 1);
        step(1, 32'h200);
        lat_min = 1;
        lat_max = 1;
        repeat (20) step();
        check("sq1_first_pc", first_pc, 32'h200);
        // Squash coinciding with a response, then a second squash two cycles later.
        lat_min = 2;
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            @(negedge clock);
            #1;
            found = mem_q.size() > 0 && mem_q[0].due <= cyc + 1;
        end
        check("rsp_due_reached", found, 1);
        step(1, 32'h300);
        step();
        step(1, 32'h403);
        repeat (20) step();
        check("sq2_first_pc", first_pc, 32'h400);
        // Random traffic with random redirects.
        lat_min = 1;
        lat_max = 5;
        ready_pct = 70;
        full_pct = 30;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) step(1, $urandom);
            else step();
        end
        // Reset pulsed in the middle of traffic.
        @(posedge clock);
        #3;
        reset_n = 0;
        #1;
        check("midrst_req_valid", bus.imem_req_valid, 0);
        check("midrst_packet", bus.if_ib_packet, 0);
        mem_q.delete();
        sb.delete();
        exp_pc = 0;
        epoch++;
        want_first = 1;
        first_pc = 'x;
        ready_pct = 100;
        full_pct = 0;
        lat_max = 1;
        repeat (2) @(posedge clock);
        release_reset();
        repeat (20) step();
        check("midrst_first_pc", first_pc, 32'h0);
        // Drain: stop issuing and let every word come out.
        ready_pct = 0;
        for (int i = 0; i < 60 && (sb.size() + mem_q.size()) != 0; i++) step();
        @(negedge clock);
        #1;
        check("drain_empty", sb.size() + mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
